// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg - parametrised UART transmitter with valid/ready input queue.
//
// Frames are: one start bit (0), DATA_BITS data bits LSB first, an optional
// odd/even parity bit, then STOP_BITS stop bits (1). Every bit lasts exactly
// CLK_DIV clk cycles. A frame that ends with more work queued is followed by
// the next start bit on the very same edge, so back-to-back frames have no
// idle gap.
//
// Build option:
//   UART_TX_FIFO_EN  defined   -> queue is a 2^FIFO_AW-entry circular FIFO
//                    undefined -> queue is a single holding register
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   data   in   word to send (DATA_BITS wide)
//   valid  in   data is offered
//   ready  out  queue not full; word taken on an edge with valid && ready
//   tx     out  registered serial line, idle high
//   busy   out  frame on the line or any word queued
//   level  out  number of queued words (not counting the frame on the line)

module uart_tx_cfg #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic [FIFO_AW:0]     level
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
`ifdef UART_TX_FIFO_EN
    if (FIFO_AW < 1 || FIFO_AW > 16) begin : g_bad_fifo_aw
        $error("uart_tx_cfg: FIFO_AW must be in 1..16 with the FIFO enabled");
    end
`else
    if (FIFO_AW < 0 || FIFO_AW > 16) begin : g_bad_fifo_aw
        $error("uart_tx_cfg: FIFO_AW must be in 0..16");
    end
`endif

    localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic        LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input queue
    // ------------------------------------------------------------------
    logic                 push;
    logic                 pop;
    logic                 q_empty;
    logic                 q_full;
    logic [DATA_BITS-1:0] q_data;

    assign push  = valid && ready;
    assign ready = !q_full;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_reg;
    logic [FIFO_AW-1:0]   rd_ptr_reg;
    logic [FIFO_AW:0]     count_reg;

    // Storage has no reset; only the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The head word is read combinationally so that a pop can load the
    // shifter on the same edge that retires it from the queue.
    assign q_data  = mem[rd_ptr_reg];
    assign q_empty = (count_reg == '0);
    assign q_full  = (count_reg == CNT_MAX);
    assign level   = count_reg;
`else
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            if (push) begin
                hold_reg      <= data;
                hold_full_reg <= 1'b1;
            end else if (pop) begin
                hold_full_reg <= 1'b0;
            end
        end
    end

    assign q_data  = hold_reg;
    assign q_empty = !hold_full_reg;
    assign q_full  = hold_full_reg;
    assign level   = (FIFO_AW+1)'(hold_full_reg);
`endif

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_reg,  state_next;
    logic                 tx_reg,     tx_next;
    logic [15:0]          cnt_reg,    cnt_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic [3:0]           bit_reg,    bit_next;
    logic                 stop_reg,   stop_next;
    logic                 par_reg,    par_next;
    logic                 bit_end;
    logic                 q_parity;

    // Parity bit for the head word, latched when the word is popped.
    assign q_parity = (PARITY == 1) ? ~^q_data : ^q_data;
    assign bit_end  = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            cnt_reg   <= '0;
            shift_reg <= '0;
            bit_reg   <= '0;
            stop_reg  <= 1'b0;
            par_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            stop_reg  <= stop_next;
            par_reg   <= par_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_next    = tx_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        stop_next  = stop_reg;
        par_next   = par_reg;
        pop        = 1'b0;

        if (state_reg != IDLE && !bit_end) begin
            cnt_next = cnt_reg - 16'd1;
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!q_empty) begin
                    pop        = 1'b1;
                    shift_next = q_data;
                    par_next   = q_parity;
                    tx_next    = 1'b0;
                    cnt_next   = DIV_M1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    bit_next   = '0;
                    cnt_next   = DIV_M1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = DIV_M1;
                    if (bit_reg == LAST_BIT) begin
                        stop_next = 1'b0;
                        if (PARITY != 0) begin
                            tx_next    = par_reg;
                            state_next = PAR;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                        bit_next   = bit_reg + 4'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    stop_next  = 1'b0;
                    cnt_next   = DIV_M1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_reg == LAST_STOP) begin
                        // Chain straight into the next start bit when work
                        // is waiting, otherwise return to idle.
                        if (!q_empty) begin
                            pop        = 1'b1;
                            shift_next = q_data;
                            par_next   = q_parity;
                            tx_next    = 1'b0;
                            cnt_next   = DIV_M1;
                            state_next = START;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = 1'b1;
                        cnt_next  = DIV_M1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Four instances with different frame formats
// run side by side; each is paired with a line model that turns accepted
// words into a per-cycle list of expected line levels.
//   inst 0: 8N1    inst 1: 8E1    inst 2: 7N2    inst 3: 8O1   (CLK_DIV=4)

module tb_uart_tx_cfg;

    localparam int NI   = 4;
    localparam int CDIV = 4;
    localparam int FAW  = 2;
`ifdef UART_TX_FIFO_EN
    localparam int QD = 1 << FAW;
`else
    localparam int QD = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [8:0]   data_v  [NI];
    logic         valid_v [NI];
    logic         ready_w [NI];
    logic         tx_w    [NI];
    logic         busy_w  [NI];
    logic [FAW:0] level_w [NI];

    logic         exp_tx    [NI];
    logic         exp_busy  [NI];
    logic         exp_ready [NI];
    logic [FAW:0] exp_level [NI];
    logic         acc_a     [NI];

    int  errors = 0;
    int  checks = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t",
                     name, idx, act, req, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int DB  = (gi == 2) ? 7 : 8;
        localparam int PAR = (gi == 1) ? 2 : ((gi == 3) ? 1 : 0);
        localparam int SB  = (gi == 2) ? 2 : 1;
        localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

        uart_tx_cfg #(
            .CLK_DIV  (CDIV),
            .DATA_BITS(DB),
            .PARITY   (PAR),
            .STOP_BITS(SB),
            .FIFO_AW  (FAW)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .data (data_v[gi][DB-1:0]),
            .valid(valid_v[gi]),
            .ready(ready_w[gi]),
            .tx   (tx_w[gi]),
            .busy (busy_w[gi]),
            .level(level_w[gi])
        );

        // Line model: m_wave holds the expected line level for each coming
        // clk cycle of the frame in progress; m_pend holds accepted words.
        logic         m_wave [$];
        logic [8:0]   m_pend [$];
        logic         m_tx    = 1'b1;
        logic         m_busy  = 1'b0;
        logic         m_ready = 1'b1;
        logic         m_acc   = 1'b0;
        logic [FAW:0] m_level = '0;
        logic [8:0]   w;
        logic         v;
        int           ones;

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_wave.delete();
                m_pend.delete();
                m_acc = 1'b0;
            end else begin
                m_acc = valid_v[gi] && (m_pend.size() < QD);
                if (m_wave.size() > 0) void'(m_wave.pop_front());
                if (m_wave.size() == 0 && m_pend.size() > 0) begin
                    w    = m_pend.pop_front();
                    ones = $countones(w);
                    for (int b = 0; b < NB; b++) begin
                        if (b == 0)                         v = 1'b0;
                        else if (b <= DB)                   v = w[b-1];
                        else if (b == DB + 1 && PAR != 0)   v = (PAR == 2) ? ones[0] : ~ones[0];
                        else                                v = 1'b1;
                        for (int c = 0; c < CDIV; c++) m_wave.push_back(v);
                    end
                end
                if (m_acc) begin
                    m_pend.push_back(9'(data_v[gi][DB-1:0]));
                    $display("inst%0d accept word %0h queued %0d at %0t",
                             gi, data_v[gi][DB-1:0], m_pend.size(), $time);
                end
            end
            m_tx    = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
            m_busy  = (m_wave.size() > 0) || (m_pend.size() > 0);
            m_level = (FAW+1)'(m_pend.size());
            m_ready = (m_pend.size() < QD);
        end

        assign exp_tx[gi]    = m_tx;
        assign exp_busy[gi]  = m_busy;
        assign exp_ready[gi] = m_ready;
        assign exp_level[gi] = m_level;
        assign acc_a[gi]     = m_acc;
    end

    // Cycle-by-cycle comparison against the models, away from the clk edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("tx",    i, 32'(tx_w[i]),    32'(exp_tx[i]));
                check("busy",  i, 32'(busy_w[i]),  32'(exp_busy[i]));
                check("ready", i, 32'(ready_w[i]), 32'(exp_ready[i]));
                check("level", i, 32'(level_w[i]), 32'(exp_level[i]));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            check({tag, "_tx"},    i, 32'(tx_w[i]),    32'd1);
            check({tag, "_busy"},  i, 32'(busy_w[i]),  32'd0);
            check({tag, "_ready"}, i, 32'(ready_w[i]), 32'd1);
            check({tag, "_level"}, i, 32'(level_w[i]), 32'd0);
        end
    endtask

    // Hand-computed frames: 0xA5 on insts 0,1,3; 0x41 then 0x42 on inst 2.
    task automatic directed_frames();
        logic [9:0] pat_a5;
        int         busy_cnt [NI];
        logic       cap [NI][100];
        logic       sent2;
        pat_a5 = 10'b1_10100101_0;  // index = bit period: start, LSB..MSB, stop
        for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
        @(negedge clk);
        data_v[0] = 9'h0A5; data_v[1] = 9'h0A5; data_v[3] = 9'h0A5;
        data_v[2] = 9'h041;
        for (int i = 0; i < NI; i++) valid_v[i] = 1'b1;
        sent2 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("dir_level_after_accept", 0, 32'(level_w[0]), 32'd1);
                check("dir_busy_after_accept",  0, 32'(busy_w[0]),  32'd1);
                check("dir_tx_before_start",    0, 32'(tx_w[0]),    32'd1);
                valid_v[0] = 1'b0; valid_v[1] = 1'b0; valid_v[3] = 1'b0;
                data_v[2]  = 9'h042;
            end else if (!sent2 && acc_a[2]) begin
                valid_v[2] = 1'b0;
                sent2      = 1'b1;
            end
            for (int i = 0; i < NI; i++) begin
                busy_cnt[i] += int'(busy_w[i]);
                if (k >= 1) cap[i][k-1] = tx_w[i];
            end
        end
        check("dir_second_word_sent", 2, 32'(sent2), 32'd1);
        for (int b = 0; b < 10; b++) check("a5_bit", b, 32'(cap[0][b*4+2]), 32'(pat_a5[b]));
        check("a5_idle_after",  0, 32'(cap[0][40]), 32'd1);
        check("busy_len_8n1",   0, 32'(busy_cnt[0]), 32'd41);
        check("even_par_bit",   1, 32'(cap[1][38]), 32'd0);
        check("even_stop",      1, 32'(cap[1][42]), 32'd1);
        check("busy_len_8e1",   1, 32'(busy_cnt[1]), 32'd45);
        check("odd_par_bit",    3, 32'(cap[3][38]), 32'd1);
        check("busy_len_8o1",   3, 32'(busy_cnt[3]), 32'd45);
        check("7n2_last_stop",  2, 32'(cap[2][39]), 32'd1);
        check("7n2_no_gap",     2, 32'(cap[2][40]), 32'd0);
        check("7n2_w2_bit0",    2, 32'(cap[2][46]), 32'd0);
        check("7n2_w2_bit1",    2, 32'(cap[2][50]), 32'd1);
        check("7n2_idle_after", 2, 32'(cap[2][80]), 32'd1);
        check("busy_len_7n2",   2, 32'(busy_cnt[2]), 32'd81);
    endtask

    task automatic rand_step(input int pct);
        for (int i = 0; i < NI; i++) begin
            if (!valid_v[i] || acc_a[i]) begin
                valid_v[i] = ($urandom_range(99) < pct);
                data_v[i]  = 9'($urandom);
            end
        end
    endtask

    task automatic drain();
        logic any;
        for (int i = 0; i < NI; i++) valid_v[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            any = 1'b0;
            for (int i = 0; i < NI; i++) any |= busy_w[i];
            if (!any) break;
        end
        for (int i = 0; i < NI; i++) check("drain_busy", i, 32'(busy_w[i]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid_v[i] = 1'b0;
            data_v[i]  = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("por");
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        directed_frames();

        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                rand_step((ph % 2 == 1) ? 95 : 20);
            end
        end
        drain();

        // Reset in the middle of data bit 3 of a frame with words queued.
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            valid_v[i] = 1'b1;
            data_v[i]  = 9'($urandom);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) valid_v[i] = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset_tx_busy", 0, 32'(busy_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midframe");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        directed_frames();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
